// File: rtl/fifo_wr_arbiter.sv
`timescale 1ns/1ps
// Round-robin write-port arbiter that shares one fifo write side between NUM_REQ producers.
// Each grant lasts for a burst of up to MAX_BURST words and is followed by one idle bubble.
module fifo_wr_arbiter #(
  parameter int FIFO_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rstN,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [FIFO_WIDTH-1:0]         fifo_data_in,
  output logic [$clog2(NUM_REQ)-1:0]    owner_id,
  output logic                          busy
);

  localparam int OW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state_q, state_d;
  logic [OW-1:0]      owner_q, owner_d;
  logic [OW-1:0]      last_q, last_d;
  logic [BW-1:0]      burst_q, burst_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               accept;
  logic               pick_valid;
  logic [OW-1:0]      pick_idx;
  logic [OW-1:0]      cand;

  assign busy       = (state_q == GRANT);
  assign gnt        = gnt_q;
  assign owner_id   = owner_q;
  assign accept     = busy & req[owner_q] & ~fifo_full;
  assign fifo_wr_en = accept;

  always_comb begin
    fifo_data_in = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (busy && owner_q == OW'(i))
        fifo_data_in = req_data[i*FIFO_WIDTH +: FIFO_WIDTH];
    end
  end

  // Scan starts just after the previous owner so every producer gets a turn.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = OW'((int'(last_q) + i) % NUM_REQ);
      if (!pick_valid && req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= OW'(NUM_REQ - 1);
      burst_q <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      burst_q <= burst_d;
      gnt_q   <= gnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    burst_d = burst_q;
    gnt_d   = gnt_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = GRANT;
          owner_d = pick_idx;
          gnt_d   = NUM_REQ'(1) << pick_idx;
          burst_d = '0;
        end
      end
      GRANT: begin
        // A full fifo with the owner still requesting is a stall: everything holds.
        if ((accept && burst_q == BW'(MAX_BURST - 1)) || !req[owner_q]) begin
          state_d = IDLE;
          last_d  = owner_q;
          gnt_d   = '0;
          burst_d = '0;
        end else if (accept) begin
          burst_d = burst_q + BW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        burst_d = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
`timescale 1ns/1ps
// Directed testbench for fifo_wr_arbiter: reset, streaming, round-robin, stall,
// early drop and fifo fill scenarios with hand-computed expectations.
module tb_fifo_wr_arbiter;

  localparam logic [31:0] DEF_DATA = 32'h13121110;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  gnt;
  logic        fifo_full = 1'b0;
  logic        fifo_wr_en;
  logic [7:0]  fifo_data_in;
  logic [1:0]  owner_id;
  logic        busy;

  int assert_count = 0;
  int fail_count   = 0;
  int fifo_level;
  int write_count;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.FIFO_WIDTH(8), .NUM_REQ(4), .MAX_BURST(4)) dut (
    .clk          (clk),
    .rstN         (rstN),
    .req          (req),
    .req_data     (req_data),
    .gnt          (gnt),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_data_in (fifo_data_in),
    .owner_id     (owner_id),
    .busy         (busy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assert_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Inputs change just after the rising edge; outputs are sampled at the falling edge.
  task automatic applyStimulus(input logic [3:0] r, input logic f, input logic [31:0] d);
    @(posedge clk);
    #1;
    req       = r;
    fifo_full = f;
    req_data  = d;
    @(negedge clk);
  endtask

  task automatic check_cycle(input string tag, input logic [3:0] e_gnt, input logic e_busy,
                             input logic [1:0] e_owner, input logic e_wr, input logic [7:0] e_data);
    checkOutput({tag, ".gnt"}, 32'(gnt), 32'(e_gnt));
    checkOutput({tag, ".busy"}, 32'(busy), 32'(e_busy));
    if (e_busy) checkOutput({tag, ".owner"}, 32'(owner_id), 32'(e_owner));
    checkOutput({tag, ".wr_en"}, 32'(fifo_wr_en), 32'(e_wr));
    checkOutput({tag, ".data"}, 32'(fifo_data_in), 32'(e_data));
  endtask

  task automatic reset_dut();
    @(posedge clk);
    #1;
    rstN      = 1'b0;
    req       = '0;
    fifo_full = 1'b0;
    @(posedge clk);
    #1;
    rstN = 1'b1;
  endtask

  function automatic logic [31:0] slot2(input logic [7:0] w);
    return {8'h00, w, 16'h0000};
  endfunction

  always @(negedge clk) begin
    if (rstN) begin
      checkOutput("inv_onehot0", 32'($onehot0(gnt)), 32'd1);
      checkOutput("inv_wr_full", 32'(fifo_wr_en & fifo_full), 32'd0);
      checkOutput("inv_gnt_busy", 32'(gnt != '0), 32'(busy));
    end
  end

  initial begin
    // Reset held with every producer requesting, then a reset in the middle of a burst.
    req      = 4'hF;
    req_data = DEF_DATA;
    #2;
    check_cycle("t1_in_reset", 4'b0000, 1'b0, 2'd0, 1'b0, 8'h00);
    @(posedge clk);
    #1;
    rstN = 1'b1;
    applyStimulus(4'hF, 1'b0, DEF_DATA);
    check_cycle("t1_first", 4'b0001, 1'b1, 2'd0, 1'b1, 8'h10);
    applyStimulus(4'hF, 1'b0, DEF_DATA);
    check_cycle("t1_second", 4'b0001, 1'b1, 2'd0, 1'b1, 8'h10);
    #2;
    rstN = 1'b0;
    #1;
    check_cycle("t1_mid_reset", 4'b0000, 1'b0, 2'd0, 1'b0, 8'h00);
    @(posedge clk);
    #1;
    rstN = 1'b1;
    applyStimulus(4'hF, 1'b0, DEF_DATA);
    check_cycle("t1_regrant", 4'b0001, 1'b1, 2'd0, 1'b1, 8'h10);

    // Single producer streaming A0..A5 through two bursts.
    reset_dut();
    applyStimulus(4'b0100, 1'b0, slot2(8'hA0));
    check_cycle("t2_idle", 4'b0000, 1'b0, 2'd0, 1'b0, 8'h00);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(4'b0100, 1'b0, slot2(8'hA0 + 8'(k)));
      check_cycle("t2_burst1", 4'b0100, 1'b1, 2'd2, 1'b1, 8'hA0 + 8'(k));
    end
    applyStimulus(4'b0100, 1'b0, slot2(8'hA4));
    check_cycle("t2_bubble", 4'b0000, 1'b0, 2'd0, 1'b0, 8'h00);
    for (int k = 4; k < 6; k++) begin
      applyStimulus(4'b0100, 1'b0, slot2(8'hA0 + 8'(k)));
      check_cycle("t2_burst2", 4'b0100, 1'b1, 2'd2, 1'b1, 8'hA0 + 8'(k));
    end
    applyStimulus(4'b0000, 1'b0, slot2(8'hA6));
    check_cycle("t2_drop", 4'b0100, 1'b1, 2'd2, 1'b0, 8'hA6);
    applyStimulus(4'b0000, 1'b0, 32'h0);
    check_cycle("t2_released", 4'b0000, 1'b0, 2'd0, 1'b0, 8'h00);

    // All producers requesting: owners 0,1,2,3,0 with four writes each.
    reset_dut();
    applyStimulus(4'hF, 1'b0, DEF_DATA);
    check_cycle("t3_idle", 4'b0000, 1'b0, 2'd0, 1'b0, 8'h00);
    for (int n = 0; n < 5; n++) begin
      for (int b = 0; b < 4; b++) begin
        applyStimulus(4'hF, 1'b0, DEF_DATA);
        check_cycle("t3_grant", 4'(1 << (n % 4)), 1'b1, 2'(n % 4), 1'b1, 8'h10 + 8'(n % 4));
      end
      applyStimulus(4'hF, 1'b0, DEF_DATA);
      check_cycle("t3_bubble", 4'b0000, 1'b0, 2'd0, 1'b0, 8'h00);
    end

    // Owner 1 stalled by a full fifo after two writes.
    reset_dut();
    applyStimulus(4'b0010, 1'b0, DEF_DATA);
    check_cycle("t4_idle", 4'b0000, 1'b0, 2'd0, 1'b0, 8'h00);
    for (int k = 0; k < 2; k++) begin
      applyStimulus(4'b0010, 1'b0, DEF_DATA);
      check_cycle("t4_pre", 4'b0010, 1'b1, 2'd1, 1'b1, 8'h11);
    end
    for (int k = 0; k < 5; k++) begin
      applyStimulus(4'b0010, 1'b1, DEF_DATA);
      check_cycle("t4_stall", 4'b0010, 1'b1, 2'd1, 1'b0, 8'h11);
    end
    for (int k = 0; k < 2; k++) begin
      applyStimulus(4'b0010, 1'b0, DEF_DATA);
      check_cycle("t4_post", 4'b0010, 1'b1, 2'd1, 1'b1, 8'h11);
    end
    applyStimulus(4'b0010, 1'b0, DEF_DATA);
    check_cycle("t4_release", 4'b0000, 1'b0, 2'd0, 1'b0, 8'h00);

    // Owner 2 drops its request after one write; rotation continues from 3.
    reset_dut();
    applyStimulus(4'b0100, 1'b0, DEF_DATA);
    check_cycle("t5_idle", 4'b0000, 1'b0, 2'd0, 1'b0, 8'h00);
    applyStimulus(4'b0100, 1'b0, DEF_DATA);
    check_cycle("t5_write", 4'b0100, 1'b1, 2'd2, 1'b1, 8'h12);
    applyStimulus(4'b1001, 1'b0, DEF_DATA);
    check_cycle("t5_dropped", 4'b0100, 1'b1, 2'd2, 1'b0, 8'h12);
    applyStimulus(4'b1001, 1'b0, DEF_DATA);
    check_cycle("t5_bubble", 4'b0000, 1'b0, 2'd0, 1'b0, 8'h00);
    applyStimulus(4'b1001, 1'b0, DEF_DATA);
    check_cycle("t5_next", 4'b1000, 1'b1, 2'd3, 1'b1, 8'h13);

    // Fill an eight-deep fifo that is never read.
    reset_dut();
    fifo_level  = 0;
    write_count = 0;
    for (int c = 0; c < 30; c++) begin
      applyStimulus(4'hF, (fifo_level >= 8), DEF_DATA);
      if (fifo_wr_en) begin
        write_count++;
        fifo_level++;
      end
    end
    checkOutput("t6_writes", 32'(write_count), 32'd8);
    checkOutput("t6_full", 32'(fifo_full), 32'd1);
    check_cycle("t6_stalled", 4'b0100, 1'b1, 2'd2, 1'b0, 8'h12);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
